// File: rtl/laser_pulse_gen.sv
// laser_pulse_gen: programmable laser pulse train generator with safety inhibit.
// Produces bursts (num_pulses != 0) or continuous trains of cycle-exact pulses
// from configuration latched at start. The laser output is registered one cycle
// behind the phase state, so HIGH lasts exactly W cycles and LOW exactly P-W.
//
// state | meaning
// IDLE  | waiting for a valid start
// HIGH  | on phase; laser_pulse follows one cycle later
// LOW   | off phase; end-of-train decision taken on its last cycle
// FAULT | inhibit seen; waits for clear_fault with inhibit low
module laser_pulse_gen #(
  parameter int CNT_W = 32,
  parameter int NUM_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic             inhibit,
  input  logic             clear_fault,
  input  logic [CNT_W-1:0] pulse_width,
  input  logic [CNT_W-1:0] pulse_period,
  input  logic [NUM_W-1:0] num_pulses,
  output logic             laser_pulse,
  output logic             busy,
  output logic             done,
  output logic             cfg_error,
  output logic             fault,
  output logic [NUM_W-1:0] pulses_sent
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, FAULT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] lat_w, lat_w_nxt;
  logic [CNT_W-1:0] lat_p, lat_p_nxt;
  logic [NUM_W-1:0] lat_n, lat_n_nxt;
  logic [NUM_W-1:0] sent_nxt;
  logic             stop_req, stop_req_nxt;
  logic             laser_nxt, busy_nxt, done_nxt, cfg_err_nxt, fault_nxt;
  logic             cfg_ok;

  assign cfg_ok = (pulse_width != '0) && (pulse_period > pulse_width);

  // Next-state, counter reload and registered-output computation.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    lat_w_nxt    = lat_w;
    lat_p_nxt    = lat_p;
    lat_n_nxt    = lat_n;
    stop_req_nxt = stop_req;
    sent_nxt     = pulses_sent;
    laser_nxt    = (state == HIGH);
    busy_nxt     = (state == HIGH) || (state == LOW);
    done_nxt     = 1'b0;
    cfg_err_nxt  = 1'b0;

    // First HIGH cycle is the one where the registered output is still low.
    if ((state == HIGH) && !laser_pulse)
      sent_nxt = pulses_sent + NUM_W'(1);

    case (state)
      IDLE: begin
        if (start && !stop) begin
          if (cfg_ok) begin
            lat_w_nxt = pulse_width;
            lat_p_nxt = pulse_period;
            lat_n_nxt = num_pulses;
            sent_nxt  = '0;
            cnt_nxt   = pulse_width - CNT_W'(1);
            state_nxt = HIGH;
          end else begin
            cfg_err_nxt = 1'b1;
          end
        end
      end
      HIGH: begin
        if (stop)
          stop_req_nxt = 1'b1;
        if (cnt == '0) begin
          state_nxt = LOW;
          cnt_nxt   = lat_p - lat_w - CNT_W'(1);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      LOW: begin
        if (stop)
          stop_req_nxt = 1'b1;
        if (cnt == '0) begin
          // A stop arriving on the very last low cycle still ends the train.
          if (stop_req || stop || ((pulses_sent == lat_n) && (lat_n != '0))) begin
            state_nxt    = IDLE;
            done_nxt     = 1'b1;
            stop_req_nxt = 1'b0;
          end else begin
            state_nxt = HIGH;
            cnt_nxt   = lat_w - CNT_W'(1);
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      FAULT: begin
        if (clear_fault && !inhibit)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Inhibit overrides everything, including a start accepted this cycle.
    if (inhibit) begin
      state_nxt    = FAULT;
      cnt_nxt      = '0;
      lat_w_nxt    = lat_w;
      lat_p_nxt    = lat_p;
      lat_n_nxt    = lat_n;
      sent_nxt     = pulses_sent;
      stop_req_nxt = 1'b0;
      laser_nxt    = 1'b0;
      busy_nxt     = 1'b0;
      done_nxt     = 1'b0;
      cfg_err_nxt  = 1'b0;
    end

    fault_nxt = (state_nxt == FAULT);
  end

  // State, counters, latched configuration and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_w       <= '0;
      lat_p       <= '0;
      lat_n       <= '0;
      stop_req    <= 1'b0;
      pulses_sent <= '0;
      laser_pulse <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_error   <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      lat_w       <= lat_w_nxt;
      lat_p       <= lat_p_nxt;
      lat_n       <= lat_n_nxt;
      stop_req    <= stop_req_nxt;
      pulses_sent <= sent_nxt;
      laser_pulse <= laser_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      cfg_error   <= cfg_err_nxt;
      fault       <= fault_nxt;
    end
  end

endmodule

// File: doc/laser_pulse_gen.md
# laser_pulse_gen

Programmable laser pulse transmitter; drives the `laser_pulse` line that the safety pulse-width/rate checker monitors. Generates bursts or continuous trains of pulses with cycle-exact width and period from latched configuration. Honours an external safety inhibit (the OR of the checker fail flags) by forcing the output low immediately and latching a fault until cleared. Sits between the host register bank and the laser driver pin.

## Interface
- `CNT_W`, 32: width of the width/period configuration and internal cycle counter.
- `NUM_W`, 16: width of the burst pulse count and the sent-pulse counter.

- `clk`  in  1  system clock; all timing is in `clk` cycles.
- `rstn`  in  1  asynchronous active-low reset.
- `start`  in  1  level-sampled; begins a train when in IDLE.
- `stop`  in  1  level-sampled; requests a graceful end of the train.
- `inhibit`  in  1  safety inhibit; immediate abort.
- `clear_fault`  in  1  clears a latched fault.
- `pulse_width`  in  CNT_W  high time, in cycles.
- `pulse_period`  in  CNT_W  rising-edge-to-rising-edge time, in cycles.
- `num_pulses`  in  NUM_W  pulses per burst; 0 means continuous.
- `laser_pulse`  out  1  registered pulse output.
- `busy`  out  1  high in any state except IDLE and FAULT.
- `done`  out  1  one-cycle strobe when a train ends normally.
- `cfg_error`  out  1  one-cycle strobe when `start` is rejected.
- `fault`  out  1  high while in FAULT.
- `pulses_sent`  out  NUM_W  rising edges issued since the last accepted start; wraps.

## Operation
- Reset values: `laser_pulse`=0, `busy`=0, `done`=0, `cfg_error`=0, `fault`=0, `pulses_sent`=0, state=IDLE, counters=0.
- States: IDLE, HIGH, LOW, FAULT.
- IDLE: on `start`=1 and `stop`=0:
  - Config is valid when `pulse_width`≥1 and `pulse_period`>`pulse_width` (unsigned).
  - Valid: latch width, period and num_pulses; clear `pulses_sent`; go to HIGH.
  - Invalid: pulse `cfg_error`; stay in IDLE.
  - `start` and `stop` together in IDLE: stop wins; no pulse and no strobe.
- HIGH: `laser_pulse`=1 for exactly the latched width. Then go to LOW.
- LOW: `laser_pulse`=0 for period−width cycles. At the end:
  - Stop request pending, or `pulses_sent`==num_pulses with num_pulses≠0: pulse `done`, go to IDLE.
  - Otherwise: go to HIGH.
- Stop handling:
  - `stop` seen in HIGH or LOW sets an internal stop request. It is cleared on entering IDLE.
  - A pulse is never truncated, and the final low phase always completes. This way the checker never sees a short pulse or a short period.
- `pulses_sent` increments on each entry to HIGH and wraps modulo 2^NUM_W.
- Inputs `start`, `pulse_width`, `pulse_period` and `num_pulses` are ignored outside IDLE.
- Inhibit:
  - `inhibit`=1 in any state, including IDLE, moves to FAULT with `laser_pulse`=0 from the next cycle.
  - It overrides every other input, and no `done` is issued.
- FAULT: `fault`=1 and `busy`=0. Leave to IDLE only when `clear_fault`=1 and `inhibit`=0 in the same cycle. `start` is ignored in FAULT.

## Timing
- Accepted `start` sampled at edge k: `laser_pulse` rises at edge k+1.
  - Falls at edge k+1+W.
  - Next rise at edge k+1+P.
  - Rise n (1-based) at edge k+1+(n−1)·P.
- `pulses_sent` becomes n at the same edge as rise n.
- Burst of N pulses: `done` is high for the cycle following edge k+1+N·P−1. State is IDLE at edge k+1+N·P. A `start` sampled at that edge gives the next rise one cycle later, so back-to-back bursts have a period of P+1.
- `cfg_error` is high for the cycle after the rejecting edge.
- `inhibit` sampled at edge j: `laser_pulse`=0 and `fault`=1 after edge j.
- `clear_fault` sampled at edge j: `fault`=0 after edge j.
- The cycle counter is CNT_W bits and compares with ==; it cannot overflow because P ≤ 2^CNT_W−1.
- Async reset mid-train: all outputs go to their reset values immediately. No restart after release.

## Test plan
- W=3, P=10, N=2, `start` at edge 5 → rises at edges 6 and 16, falls at 9 and 19; `pulses_sent` 1 then 2; `done` after edge 25; `busy` low after edge 26.
- W=1, P=2, N=0 (continuous), `stop` pulsed during the 4th high → 4 full pulses, low phase completes, `done`, IDLE; no 5th rise.
- Invalid configs (W=0; W=5/P=5; W=6/P=5) with `start` → `cfg_error` strobe, `laser_pulse` stays 0, `pulses_sent` unchanged.
- W=100, P=200, `inhibit` at 50 cycles into the pulse → output 0 next cycle, `fault`=1. `clear_fault` while `inhibit`=1 has no effect. After `inhibit` drops, `clear_fault` returns to IDLE, and a new `start` then works.
- `start` and `stop` together in IDLE → no activity. `start` with changed W/P while busy → current train keeps the original timing.
- Loopback into the pulse checker with limits bracketing W and P → no fail flags over 1000 pulses.
